// File: rtl/trigger_ctrl.sv
// Sequencer for a bank of SUMP trigger stages: decodes stage config opcodes,
// drives arm/level to the stages and merges their run flags into one capture start.
module trigger_ctrl #(
  parameter int NUM_STAGES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            opc_i,
  input  logic [31:0]           cmd_i,
  input  logic                  cmd_stb_i,
  input  logic [NUM_STAGES-1:0] match_i,
  input  logic [NUM_STAGES-1:0] run_i,
  output logic [31:0]           stg_cmd_o,
  output logic [NUM_STAGES-1:0] set_mask_o,
  output logic [NUM_STAGES-1:0] set_val_o,
  output logic [NUM_STAGES-1:0] set_cfg_o,
  output logic                  arm_o,
  output logic [1:0]            lvl_o,
  output logic                  run_o,
  output logic                  armed_o,
  output logic                  fired_o,
  output logic                  cfg_drop_o
);

  // state | meaning
  // IDLE  | not armed; config commands forwarded to stages
  // ARMED | stages armed; level accumulates from match_i, config dropped
  // FIRED | a stage ran; level frozen, config forwarded, re-arm allowed
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic                  is_cfg, is_arm, is_srst;
  logic [NUM_STAGES-1:0] stage_sel;
  logic [2:0]            match_cnt;
  logic [2:0]            lvl_sum;
  logic [1:0]            lvl_sat;

  logic [31:0]           stg_cmd_n;
  logic [NUM_STAGES-1:0] set_mask_n, set_val_n, set_cfg_n;
  logic                  arm_n, run_n, drop_n;
  logic [1:0]            lvl_n;

  // Reserved sub-op (11) and out-of-range stages are not config commands at all
  always_comb begin
    is_cfg  = cmd_stb_i && (opc_i[7:4] == 4'hC) && (opc_i[1:0] != 2'b11) &&
              ({1'b0, opc_i[3:2]} < 3'(NUM_STAGES));
    is_arm  = cmd_stb_i && (opc_i == 8'h01);
    is_srst = cmd_stb_i && (opc_i == 8'h00);
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_sel[i] = (opc_i[3:2] == 2'(i));
    end
  end

  always_comb begin
    match_cnt = 3'd0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      match_cnt = match_cnt + {2'b00, match_i[i]};
    end
    lvl_sum = {1'b0, lvl_o} + match_cnt;
    lvl_sat = (lvl_sum > 3'd3) ? 2'd3 : lvl_sum[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    stg_cmd_n  = stg_cmd_o;
    set_mask_n = '0;
    set_val_n  = '0;
    set_cfg_n  = '0;
    arm_n      = 1'b0;
    run_n      = 1'b0;
    drop_n     = 1'b0;
    lvl_n      = lvl_o;

    if (is_srst) begin
      // soft reset wins over a coincident run_i, so no run_o follows
      state_n = S_IDLE;
      lvl_n   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_FIRED: begin
          if (is_cfg) begin
            stg_cmd_n = cmd_i;
            case (opc_i[1:0])
              2'b00:   set_mask_n = stage_sel;
              2'b01:   set_val_n  = stage_sel;
              default: set_cfg_n  = stage_sel;
            endcase
          end else if (is_arm) begin
            state_n = S_ARMED;
            arm_n   = 1'b1;
            lvl_n   = 2'd0;
          end
        end
        S_ARMED: begin
          drop_n = is_cfg;
          lvl_n  = lvl_sat;
          if (|run_i) begin
            state_n = S_FIRED;
            run_n   = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_cmd_o  <= '0;
      set_mask_o <= '0;
      set_val_o  <= '0;
      set_cfg_o  <= '0;
      arm_o      <= 1'b0;
      lvl_o      <= 2'd0;
      run_o      <= 1'b0;
      armed_o    <= 1'b0;
      fired_o    <= 1'b0;
      cfg_drop_o <= 1'b0;
    end else begin
      stg_cmd_o  <= stg_cmd_n;
      set_mask_o <= set_mask_n;
      set_val_o  <= set_val_n;
      set_cfg_o  <= set_cfg_n;
      arm_o      <= arm_n;
      lvl_o      <= lvl_n;
      run_o      <= run_n;
      armed_o    <= (state_n == S_ARMED);
      fired_o    <= (state_n == S_FIRED);
      cfg_drop_o <= drop_n;
    end
  end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed scoreboard bench for trigger_ctrl; a 4-stage and a 2-stage instance
// share the command bus so stage-index bounds can be checked side by side.
module tb_trigger_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  opc_i;
  logic [31:0] cmd_i;
  logic        cmd_stb_i;
  logic [3:0]  match_i, run_i;

  logic [31:0] stg_cmd4, stg_cmd2;
  logic [3:0]  mask4, val4, cfg4;
  logic [1:0]  mask2, val2, cfg2;
  logic        arm4, run4, armed4, fired4, drop4;
  logic        arm2, run2, armed2, fired2, drop2;
  logic [1:0]  lvl4, lvl2;

  typedef struct packed {
    logic [31:0] stg;
    logic [3:0]  mask, val, cfg;
    logic        arm;
    logic [1:0]  lvl;
    logic        run, armed, fired, drop;
  } out4_t;

  typedef struct packed {
    logic [31:0] stg;
    logic [1:0]  mask, val, cfg;
    logic        drop;
  } out2_t;

  typedef struct {
    string tag;
    out4_t e4;
    bit    chk2;
    out2_t e2;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  trigger_ctrl #(.NUM_STAGES(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .opc_i(opc_i), .cmd_i(cmd_i), .cmd_stb_i(cmd_stb_i),
    .match_i(match_i), .run_i(run_i), .stg_cmd_o(stg_cmd4), .set_mask_o(mask4),
    .set_val_o(val4), .set_cfg_o(cfg4), .arm_o(arm4), .lvl_o(lvl4), .run_o(run4),
    .armed_o(armed4), .fired_o(fired4), .cfg_drop_o(drop4)
  );

  trigger_ctrl #(.NUM_STAGES(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .opc_i(opc_i), .cmd_i(cmd_i), .cmd_stb_i(cmd_stb_i),
    .match_i(match_i[1:0]), .run_i(run_i[1:0]), .stg_cmd_o(stg_cmd2), .set_mask_o(mask2),
    .set_val_o(val2), .set_cfg_o(cfg2), .arm_o(arm2), .lvl_o(lvl2), .run_o(run2),
    .armed_o(armed2), .fired_o(fired2), .cfg_drop_o(drop2)
  );

  function automatic out4_t o4(input logic [31:0] stg, input logic [3:0] mask, val, cfg,
                               input logic arm, input logic [1:0] lvl,
                               input logic run, armed, fired, drop);
    o4 = '{stg: stg, mask: mask, val: val, cfg: cfg, arm: arm, lvl: lvl,
           run: run, armed: armed, fired: fired, drop: drop};
  endfunction

  function automatic out2_t o2(input logic [31:0] stg, input logic [1:0] mask, val, cfg,
                               input logic drop);
    o2 = '{stg: stg, mask: mask, val: val, cfg: cfg, drop: drop};
  endfunction

  // Drive one cycle of stimulus, queue the expectation, then check after the edge
  task automatic step(input string tag, input logic r, input logic stb,
                      input logic [7:0] opc, input logic [31:0] cmd,
                      input logic [3:0] m, input logic [3:0] rn,
                      input out4_t e4, input bit chk2 = 1'b0,
                      input out2_t e2 = '0);
    exp_t e, got;
    out4_t a4;
    out2_t a2;
    @(negedge clk_i);
    rst_i = r; cmd_stb_i = stb; opc_i = opc; cmd_i = cmd; match_i = m; run_i = rn;
    e.tag = tag; e.e4 = e4; e.chk2 = chk2; e.e2 = e2;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = exp_q.pop_front();
    a4 = '{stg: stg_cmd4, mask: mask4, val: val4, cfg: cfg4, arm: arm4, lvl: lvl4,
           run: run4, armed: armed4, fired: fired4, drop: drop4};
    tests++;
    assert (a4 === got.e4) else begin
      fails++;
      $error("FAIL %s n4: observed %h expected %h", got.tag, a4, got.e4);
    end
    if (got.chk2) begin
      a2 = '{stg: stg_cmd2, mask: mask2, val: val2, cfg: cfg2, drop: drop2};
      tests++;
      assert (a2 === got.e2) else begin
        fails++;
        $error("FAIL %s n2: observed %h expected %h", got.tag, a2, got.e2);
      end
    end
  endtask

  localparam logic [31:0] S0 = 32'hDEADBEEF;
  localparam logic [31:0] S1 = 32'h11112222;
  localparam logic [31:0] S2 = 32'hCAFEF00D;
  localparam logic [31:0] S3 = 32'hAAAA5555;

  initial begin
    rst_i = 1'b1; cmd_stb_i = 1'b0; opc_i = '0; cmd_i = '0; match_i = '0; run_i = '0;

    step("reset0", 1, 0, 8'h00, 0, 0, 0, o4(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, o2(0, 0, 0, 0, 0));
    step("reset1", 1, 1, 8'hC4, S0, 4'hF, 4'hF, o4(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("cfg_mask1", 0, 1, 8'hC4, S0, 0, 0, o4(S0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0),
         1, o2(S0, 2'b10, 0, 0, 0));
    step("hold_idle", 0, 0, 8'hC4, 32'h0, 0, 0, o4(S0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("cfg_val2", 0, 1, 8'hC9, S1, 0, 0, o4(S1, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0),
         1, o2(S0, 0, 0, 0, 0));
    step("reserved", 0, 1, 8'hC3, 32'h99999999, 0, 0, o4(S1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("unknown_op", 0, 1, 8'h55, 32'h77777777, 0, 0, o4(S1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bound_idle", 0, 1, 8'hCD, S2, 0, 0, o4(S2, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0),
         1, o2(S0, 0, 0, 0, 0));
    step("arm", 0, 1, 8'h01, 0, 0, 0, o4(S2, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    step("match1", 0, 0, 8'h00, 0, 4'b0001, 0, o4(S2, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    step("rearm_ign", 0, 1, 8'h01, 0, 0, 0, o4(S2, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    step("fire", 0, 0, 8'h00, 0, 0, 4'b0100, o4(S2, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    step("fired_hold", 0, 0, 8'h00, 0, 0, 0, o4(S2, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step("fired_ign", 0, 0, 8'h00, 0, 4'b1111, 4'b0001, o4(S2, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step("fired_cfg", 0, 1, 8'hC2, S3, 0, 0, o4(S3, 0, 0, 4'b0001, 0, 1, 0, 0, 1, 0),
         1, o2(S3, 0, 0, 2'b01, 0));
    step("rearm_fired", 0, 1, 8'h01, 0, 0, 0, o4(S3, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    step("sat_1111", 0, 0, 8'h00, 0, 4'b1111, 0, o4(S3, 0, 0, 0, 0, 3, 0, 1, 0, 0));
    step("sat_hold", 0, 0, 8'h00, 0, 4'b0001, 0, o4(S3, 0, 0, 0, 0, 3, 0, 1, 0, 0));
    step("bound_armed", 0, 1, 8'hCD, 32'h0BADF00D, 0, 0, o4(S3, 0, 0, 0, 0, 3, 0, 1, 0, 1),
         1, o2(S3, 0, 0, 0, 0));
    step("drop_cfg", 0, 1, 8'hC2, 32'h12345678, 0, 0, o4(S3, 0, 0, 0, 0, 3, 0, 1, 0, 1));
    step("srst_run", 0, 1, 8'h00, 0, 4'b0001, 4'b0001, o4(S3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("after_srst", 0, 0, 8'h00, 0, 0, 0, o4(S3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("arm2", 0, 1, 8'h01, 0, 0, 0, o4(S3, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    step("match_run", 0, 0, 8'h00, 0, 4'b0011, 4'b1000, o4(S3, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    step("srst_fired", 0, 1, 8'h00, 0, 0, 0, o4(S3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("arm3", 0, 1, 8'h01, 0, 0, 0, o4(S3, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    step("fire3", 0, 0, 8'h00, 0, 0, 4'b0001, o4(S3, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step("rst_fired", 1, 1, 8'hC4, 32'h5A5A5A5A, 4'hF, 4'hF,
         o4(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, o2(0, 0, 0, 0, 0));
    step("post_rst", 0, 0, 8'h00, 0, 0, 0, o4(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("b2b_val0", 0, 1, 8'hC1, 32'h5, 0, 0, o4(32'h5, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    step("b2b_cfg1", 0, 1, 8'hC6, 32'h6, 0, 0, o4(32'h6, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
    step("b2b_idle", 0, 0, 8'h00, 0, 0, 0, o4(32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trigger_ctrl.md
Name: trigger_ctrl

Overview:
- Sequencer for the bank of SUMP trigger stages; sits between the command decoder and the stage instances.
- Decodes stage-configuration opcodes into per-stage set_mask/set_val/set_cfg strobes and forwards the 32-bit payload.
- Issues the arm pulse and maintains the shared trigger level from stage match pulses.
- Merges stage run flags into a single capture-start pulse for the sampler.

Parameters:
NUM_STAGES, 4, number of trigger stages served; legal range 1..4.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
opc_i  in  8  SUMP opcode, valid with cmd_stb_i
cmd_i  in  32  command payload, valid with cmd_stb_i
cmd_stb_i  in  1  command strobe, one cycle per command
match_i  in  NUM_STAGES  per-stage match pulse
run_i  in  NUM_STAGES  per-stage run pulse
stg_cmd_o  out  32  payload forwarded to all stages
set_mask_o  out  NUM_STAGES  per-stage set-mask strobe
set_val_o  out  NUM_STAGES  per-stage set-value strobe
set_cfg_o  out  NUM_STAGES  per-stage set-config strobe
arm_o  out  1  arm pulse to all stages
lvl_o  out  2  current trigger level to all stages
run_o  out  1  capture-start pulse
armed_o  out  1  high while in ARMED
fired_o  out  1  high while in FIRED
cfg_drop_o  out  1  pulse: config command dropped while armed

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset sets the state to IDLE.
- Reset asserted mid-operation aborts immediately. No stale strobes are emitted afterwards.
- Decode applies only when cmd_stb_i=1. Stage index n = opc_i[3:2].
  - 0xC0|n<<2: set mask
  - 0xC1|n<<2: set value
  - 0xC2|n<<2: set config
  - 0xC3|n<<2: reserved, ignored
  - 0x01: arm
  - 0x00: soft reset
  - Any other opcode is ignored.
  - Config opcodes with n >= NUM_STAGES are ignored, with no strobe and no drop flag.
- Config latency: one cycle after cmd_stb_i, exactly one strobe bit is high for one cycle.
  - stg_cmd_o is updated on the same cycle as the strobe and holds until the next accepted config command.
- States: IDLE, ARMED, FIRED.
  - IDLE:
    - Config commands are forwarded.
    - Arm -> ARMED. On the next cycle: arm_o=1 for one cycle, lvl_o=0.
  - ARMED:
    - Config commands are not forwarded. cfg_drop_o pulses one cycle later.
    - Arm is ignored.
    - Each cycle, lvl_o increases by popcount(match_i), saturating at 3. The sum is computed 3 bits wide, then clamped.
    - If any run_i=1 -> FIRED. run_o=1 for one cycle on the next cycle.
    - run_i and match_i in the same cycle: the level update is applied and FIRED is still entered.
    - run_i seen in IDLE or FIRED is ignored.
  - FIRED:
    - Config commands are forwarded.
    - lvl_o holds.
    - Arm -> ARMED, with the same arm behaviour as in IDLE (re-arm, level cleared).
- Soft reset 0x00: from any state -> IDLE on the next cycle.
  - lvl_o=0, armed_o=0, fired_o=0.
  - stg_cmd_o holds.
  - A pending run_o is suppressed if soft reset and run_i coincide.
- armed_o and fired_o follow the registered state with no glitches. They are never high together.
- At most one command is handled per cycle. There is no back-pressure; commands arriving every cycle are all handled.

Test Plan:
- Config forwarding: after reset, cmd_stb_i with opc_i=0xC4, cmd_i=0xDEADBEEF -> next cycle set_mask_o=4'b0010, stg_cmd_o=0xDEADBEEF; all other strobes 0.
- Arm and fire: opc_i=0x01, then match_i=4'b0001, then run_i=4'b0100 -> arm_o pulses once; lvl_o goes 0->1; run_o pulses one cycle after run_i; fired_o=1, armed_o=0.
- Level saturation: in ARMED, match_i=4'b1111 -> lvl_o=3; a further match_i=4'b0001 -> lvl_o stays 3.
- Drop while armed: in ARMED, opc_i=0xC2, cmd_i=0x12345678 -> no set_cfg_o; cfg_drop_o pulses; stg_cmd_o is unchanged.
- Soft reset coincident with run: in ARMED, cmd_stb_i with opc_i=0x00 in the same cycle as run_i=4'b0001 -> no run_o; state IDLE; lvl_o=0.
- Bounds and reset: with NUM_STAGES=2, opc_i=0xCD -> no strobe and no drop. rst_i asserted while FIRED -> all outputs 0 on the next cycle.
